// File: rtl/tx_pkt_scheduler.sv
// Packet-granular round-robin scheduler that merges NUM_PORTS AXI-Stream requesters
// into the single tx_queue write port, with a per-port enable mask and inter-packet gap.
module tx_pkt_scheduler #(
    parameter int NUM_PORTS      = 4,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int TUSER_WIDTH    = 512,
    parameter int GAP_WIDTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0]      s_tuser,
    input  logic [NUM_PORTS-1:0]                  s_tvalid,
    input  logic [NUM_PORTS-1:0]                  s_tlast,
    output logic [NUM_PORTS-1:0]                  s_tready,
    output logic [AXI_DATA_WIDTH-1:0]             m_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0]           m_tkeep,
    output logic [TUSER_WIDTH-1:0]                m_tuser,
    output logic                                  m_tvalid,
    output logic                                  m_tlast,
    input  logic                                  m_tready,
    input  logic [NUM_PORTS-1:0]                  cfg_port_en,
    input  logic [GAP_WIDTH-1:0]                  cfg_gap,
    output logic                                  pkt_sent,
    output logic [2:0]                            pkt_sent_port,
    output logic [15:0]                           pkt_sent_bytes
);

    localparam int KEEP_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int IDXW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                     state;
    logic [IDXW-1:0]            grant;
    logic [IDXW-1:0]            last_grant;
    logic [IDXW-1:0]            arb_grant;
    logic [IDXW:0]              arb_sum;
    logic [GAP_WIDTH-1:0]       gap_cnt;
    logic                       first_beat;
    logic [15:0]                byte_reg;
    logic [NUM_PORTS-1:0]       req;
    logic [2*NUM_PORTS-1:0]     req_dbl;
    logic [2*NUM_PORTS-1:0]     req_rot;
    logic                       in_send;
    logic                       beat_acc;

    assign req      = s_tvalid & cfg_port_en;
    assign req_dbl  = {req, req};
    assign req_rot  = req_dbl >> ({1'b0, last_grant} + (IDXW+1)'(1));
    assign in_send  = (state == SEND);
    assign beat_acc = m_tvalid & m_tready;

    // Rotate requests so bit 0 is the port after last_grant; the lowest set bit wins.
    always_comb begin
        arb_grant = '0;
        arb_sum   = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                arb_sum = {1'b0, last_grant} + (IDXW+1)'(1) + (IDXW+1)'(j);
                if (arb_sum >= (IDXW+1)'(NUM_PORTS)) begin
                    arb_sum = arb_sum - (IDXW+1)'(NUM_PORTS);
                end
                arb_grant = arb_sum[IDXW-1:0];
            end
        end
    end

    always_comb begin
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tuser  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (in_send) begin
            m_tdata         = s_tdata[grant*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            m_tkeep         = s_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH];
            m_tuser         = s_tuser[grant*TUSER_WIDTH +: TUSER_WIDTH];
            m_tvalid        = s_tvalid[grant];
            m_tlast         = s_tlast[grant];
            s_tready[grant] = m_tready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= '0;
            last_grant     <= IDXW'(NUM_PORTS - 1);
            gap_cnt        <= '0;
            first_beat     <= 1'b0;
            byte_reg       <= '0;
            pkt_sent       <= 1'b0;
            pkt_sent_port  <= '0;
            pkt_sent_bytes <= '0;
        end else begin
            pkt_sent <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant      <= arb_grant;
                        first_beat <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (beat_acc) begin
                        first_beat <= 1'b0;
                        if (first_beat) begin
                            byte_reg <= m_tuser[15:0];
                        end
                        // A single-beat packet reports the length straight off the bus.
                        if (m_tlast) begin
                            pkt_sent       <= 1'b1;
                            pkt_sent_port  <= 3'(grant);
                            pkt_sent_bytes <= first_beat ? m_tuser[15:0] : byte_reg;
                            last_grant     <= grant;
                            gap_cnt        <= cfg_gap;
                            state          <= (cfg_gap != '0) ? GAP : IDLE;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_pkt_scheduler.sv
// Directed bench for tx_pkt_scheduler: per-port packet sources feed the DUT, a cycle table
// covers round-robin order and hand-written sequences cover the multi-cycle corner cases.
module tb_tx_pkt_scheduler;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int KW = DW / 8;
    localparam int GW = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NP*DW-1:0]   s_tdata;
    logic [NP*KW-1:0]   s_tkeep;
    logic [NP*TW-1:0]   s_tuser;
    logic [NP-1:0]      s_tvalid;
    logic [NP-1:0]      s_tlast;
    logic [NP-1:0]      s_tready;
    logic [DW-1:0]      m_tdata;
    logic [KW-1:0]      m_tkeep;
    logic [TW-1:0]      m_tuser;
    logic               m_tvalid;
    logic               m_tlast;
    logic               m_tready;
    logic [NP-1:0]      cfg_port_en;
    logic [GW-1:0]      cfg_gap;
    logic               pkt_sent;
    logic [2:0]         pkt_sent_port;
    logic [15:0]        pkt_sent_bytes;

    int n_checks = 0;
    int n_fail   = 0;

    int src_pkt  [NP];
    int src_beat [NP];
    int src_len  [NP];
    int src_left [NP];
    bit src_hold [NP];

    typedef struct {
        logic          rdy_in;
        logic          valid;
        logic [NP-1:0] ready;
        logic          last;
        int            port;
        int            pkt;
        int            beat;
        logic          sent;
        int            sent_port;
    } vec_t;

    vec_t vecs [16];

    tx_pkt_scheduler #(
        .NUM_PORTS      (NP),
        .AXI_DATA_WIDTH (DW),
        .TUSER_WIDTH    (TW),
        .GAP_WIDTH      (GW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tuser        (s_tuser),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tuser        (m_tuser),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .cfg_port_en    (cfg_port_en),
        .cfg_gap        (cfg_gap),
        .pkt_sent       (pkt_sent),
        .pkt_sent_port  (pkt_sent_port),
        .pkt_sent_bytes (pkt_sent_bytes)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] beatData(input int p, input int k, input int b);
        return {8'(p), 8'(k), 16'(b)};
    endfunction

    function automatic logic [15:0] pktBytes(input int p, input int len);
        return 16'(len * 64 + p);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sources present the first beat's tuser as the length and junk on later beats.
    task automatic driveBus();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p]           = (src_left[p] > 0) && !src_hold[p];
            s_tlast[p]            = (src_beat[p] == src_len[p] - 1);
            s_tdata[p*DW +: DW]   = beatData(p, src_pkt[p], src_beat[p]);
            s_tkeep[p*KW +: KW]   = '1;
            s_tuser[p*TW +: TW]   = (src_beat[p] == 0) ? pktBytes(p, src_len[p]) : 16'hDEAD;
        end
    endtask

    task automatic setupSources(input int len, input logic [NP-1:0] mask, input int npk);
        for (int p = 0; p < NP; p++) begin
            src_pkt[p]  = 0;
            src_beat[p] = 0;
            src_len[p]  = len;
            src_left[p] = mask[p] ? npk : 0;
            src_hold[p] = 1'b0;
        end
        driveBus();
    endtask

    task automatic applyStimulus(input logic rdy, input logic [NP-1:0] en, input logic [GW-1:0] gap);
        m_tready    = rdy;
        cfg_port_en = en;
        cfg_gap     = gap;
        #1;
    endtask

    // One clock: handshakes are taken mid-cycle, sources advance just after the edge.
    task automatic tick();
        logic [NP-1:0] fire;
        fire = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (fire[p]) begin
                if (src_beat[p] == src_len[p] - 1) begin
                    src_beat[p] = 0;
                    src_pkt[p]++;
                    src_left[p]--;
                end else begin
                    src_beat[p]++;
                end
            end
        end
        driveBus();
        @(negedge clk);
    endtask

    task automatic startTest(input int len, input logic [NP-1:0] mask, input int npk, input logic [GW-1:0] gap);
        reset = 1'b1;
        @(negedge clk);
        setupSources(len, mask, npk);
        applyStimulus(1'b1, '1, gap);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic countIdle(input int start, output int n);
        n = start;
        while (!m_tvalid && n < 30) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int cyc;
        int got [3];
        int exp_port [3];
        int exp_beat;
        bit done;
        bit hold;
        logic rdy;

        reset = 1'b1;
        setupSources(1, '0, 0);
        applyStimulus(1'b0, '0, '0);

        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 0, 0, 0, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b1, 4'b0001, 1'b1, 0, 0, 1, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b1, 0};
        vecs[4]  = '{1'b1, 1'b1, 4'b0010, 1'b0, 1, 0, 0, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b1, 4'b0010, 1'b1, 1, 0, 1, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b1, 1};
        vecs[7]  = '{1'b1, 1'b1, 4'b0100, 1'b0, 2, 0, 0, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 2, 0, 1, 1'b0, 0};
        vecs[9]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b1, 2};
        vecs[10] = '{1'b1, 1'b1, 4'b1000, 1'b0, 3, 0, 0, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b1, 4'b1000, 1'b1, 3, 0, 1, 1'b0, 0};
        vecs[12] = '{1'b1, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b1, 3};
        vecs[13] = '{1'b1, 1'b1, 4'b0001, 1'b0, 0, 1, 0, 1'b0, 0};
        vecs[14] = '{1'b1, 1'b1, 4'b0001, 1'b1, 0, 1, 1, 1'b0, 0};
        vecs[15] = '{1'b1, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b1, 0};

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_m_tvalid", m_tvalid, 0);
        checkOutput("rst_s_tready", s_tready, 0);
        checkOutput("rst_pkt_sent", pkt_sent, 0);
        checkOutput("rst_pkt_sent_port", pkt_sent_port, 0);
        checkOutput("rst_pkt_sent_bytes", pkt_sent_bytes, 0);

        $display("[TB] round-robin table, 4 ports, 2-beat packets, gap 0");
        startTest(2, 4'hF, 2, 16'd0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            applyStimulus(vecs[i].rdy_in, 4'hF, 16'd0);
            checkOutput($sformatf("t1_valid[%0d]", i), m_tvalid, vecs[i].valid);
            checkOutput($sformatf("t1_ready[%0d]", i), s_tready, vecs[i].ready);
            checkOutput($sformatf("t1_sent[%0d]", i), pkt_sent, vecs[i].sent);
            if (vecs[i].valid) begin
                checkOutput($sformatf("t1_data[%0d]", i), m_tdata,
                            beatData(vecs[i].port, vecs[i].pkt, vecs[i].beat));
                checkOutput($sformatf("t1_last[%0d]", i), m_tlast, vecs[i].last);
                checkOutput($sformatf("t1_keep[%0d]", i), m_tkeep, {KW{1'b1}});
                checkOutput($sformatf("t1_user[%0d]", i), m_tuser,
                            (vecs[i].beat == 0) ? pktBytes(vecs[i].port, 2) : 16'hDEAD);
            end
            if (vecs[i].sent) begin
                checkOutput($sformatf("t1_sent_port[%0d]", i), pkt_sent_port, vecs[i].sent_port);
                checkOutput($sformatf("t1_sent_bytes[%0d]", i), pkt_sent_bytes, pktBytes(vecs[i].sent_port, 2));
            end
        end

        $display("[TB] single requester, port 2, three packets");
        startTest(2, 4'b0100, 3, 16'd0);
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (pkt_sent) begin
                checkOutput($sformatf("t2_port[%0d]", n), pkt_sent_port, 2);
                checkOutput($sformatf("t2_cycle[%0d]", n), c, 3 * (n + 1));
                checkOutput($sformatf("t2_bubble[%0d]", n), m_tvalid, 0);
                n++;
            end
        end
        checkOutput("t2_pkt_count", n, 3);

        $display("[TB] gap of 5 with single-beat packets, gap changed mid-gap");
        startTest(1, 4'b0001, 3, 16'd5);
        tick();
        checkOutput("t3_first_valid", m_tvalid, 1);
        checkOutput("t3_first_last", m_tlast, 1);
        checkOutput("t3_first_data", m_tdata, beatData(0, 0, 0));
        tick();
        checkOutput("t3_sent", pkt_sent, 1);
        checkOutput("t3_sent_port", pkt_sent_port, 0);
        checkOutput("t3_sent_bytes", pkt_sent_bytes, pktBytes(0, 1));
        applyStimulus(1'b1, 4'hF, 16'd2);
        tick();
        checkOutput("t3_pulse_width", pkt_sent, 0);
        countIdle(1, n);
        checkOutput("t3_idle_gap5", n, 6);
        checkOutput("t3_second_data", m_tdata, beatData(0, 1, 0));
        tick();
        checkOutput("t3_second_bytes", pkt_sent_bytes, pktBytes(0, 1));
        countIdle(0, n);
        checkOutput("t3_idle_gap2", n, 3);

        $display("[TB] m_tready toggling and tvalid dropout on a 4-beat packet");
        startTest(4, 4'b1000, 1, 16'd0);
        tick();
        exp_beat = 0;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            hold = (cyc == 3 || cyc == 4);
            src_hold[3] = hold;
            driveBus();
            rdy = (cyc % 2 == 0);
            applyStimulus(rdy, 4'hF, 16'd0);
            checkOutput($sformatf("t4_valid[%0d]", cyc), m_tvalid, !hold);
            checkOutput($sformatf("t4_ready[%0d]", cyc), s_tready, {rdy, 3'b000});
            if (!hold) begin
                checkOutput($sformatf("t4_data[%0d]", cyc), m_tdata, beatData(3, 0, exp_beat));
                checkOutput($sformatf("t4_last[%0d]", cyc), m_tlast, exp_beat == 3);
                if (rdy) begin
                    if (exp_beat == 3) done = 1'b1;
                    exp_beat++;
                end
            end
            tick();
            cyc++;
        end
        src_hold[3] = 1'b0;
        checkOutput("t4_done", done, 1);
        checkOutput("t4_sent", pkt_sent, 1);
        checkOutput("t4_sent_port", pkt_sent_port, 3);
        checkOutput("t4_sent_bytes", pkt_sent_bytes, pktBytes(3, 4));

        $display("[TB] port 1 disabled mid-packet, then all ports disabled");
        startTest(3, 4'b1010, 3, 16'd0);
        tick();
        checkOutput("t5_first_data", m_tdata, beatData(1, 0, 0));
        applyStimulus(1'b1, 4'b1101, 16'd0);
        exp_port = '{1, 3, 3};
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (pkt_sent) begin
                got[n] = pkt_sent_port;
                if (n == 0) checkOutput("t5_bytes", pkt_sent_bytes, pktBytes(1, 3));
                n++;
            end
        end
        checkOutput("t5_pkt_count", n, 3);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("t5_grant[%0d]", k), got[k], exp_port[k]);
        end
        applyStimulus(1'b1, 4'b0000, 16'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("t5_dis_valid[%0d]", c), m_tvalid, 0);
            checkOutput($sformatf("t5_dis_ready[%0d]", c), s_tready, 0);
        end

        $display("[TB] reset during beat 2 of a packet");
        startTest(4, 4'hF, 2, 16'd0);
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
            if (m_tvalid && m_tdata == beatData(1, 0, 1)) done = 1'b1;
        end
        checkOutput("t6_reach_beat2", done, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_valid", m_tvalid, 0);
        checkOutput("t6_rst_ready", s_tready, 0);
        checkOutput("t6_rst_sent", pkt_sent, 0);
        setupSources(4, 4'hF, 2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t6_idle_valid", m_tvalid, 0);
        tick();
        checkOutput("t6_regrant_valid", m_tvalid, 1);
        checkOutput("t6_regrant_ready", s_tready, 4'b0001);
        checkOutput("t6_regrant_data", m_tdata, beatData(0, 0, 0));

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
